// File: rtl/log_shift_pkg.sv
// Shared definitions for the pipelined antilog barrel shifter:
// direction/fill encodings, mux-level split across stages and the
// stage payload layout {data, shamt, dir, arith, round, tag} (MSB..LSB).
package log_shift_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic FILL_ZERO = 1'b0;
    localparam logic FILL_SIGN = 1'b1;

    // Shift levels are split evenly; any remainder lands in stage 0.
    function automatic int unsigned levels_in_stage(input int unsigned stage,
                                                    input int unsigned shw,
                                                    input int unsigned pipe_stages);
        int unsigned base;
        base = shw / pipe_stages;
        return (stage == 0) ? base + (shw % pipe_stages) : base;
    endfunction

    // Index of the first shift level handled by a given stage.
    function automatic int unsigned first_level(input int unsigned stage,
                                                input int unsigned shw,
                                                input int unsigned pipe_stages);
        int unsigned base;
        base = shw / pipe_stages;
        return (stage == 0) ? 0 : base + (shw % pipe_stages) + (stage - 1) * base;
    endfunction

    function automatic int unsigned payload_w(input int unsigned width,
                                              input int unsigned shw,
                                              input int unsigned tag_w);
        return 2 * width + shw + 3 + tag_w;
    endfunction

    function automatic int unsigned round_bit(input int unsigned tag_w);
        return tag_w;
    endfunction

    function automatic int unsigned arith_bit(input int unsigned tag_w);
        return tag_w + 1;
    endfunction

    function automatic int unsigned dir_bit(input int unsigned tag_w);
        return tag_w + 2;
    endfunction

    function automatic int unsigned shamt_lsb(input int unsigned tag_w);
        return tag_w + 3;
    endfunction

    function automatic int unsigned data_lsb(input int unsigned shw,
                                             input int unsigned tag_w);
        return tag_w + 3 + shw;
    endfunction

endpackage

// File: rtl/log_shift_stage.sv
// One elastic pipeline stage: applies its share of the barrel-shifter mux
// levels to the incoming payload and registers the result. Owns its valid
// bit and load condition. The last stage may also add the rounding bit.
module log_shift_stage
    import log_shift_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SHW         = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned FIRST_LEVEL = 0,
    parameter int unsigned NUM_LEVELS  = 1,
    parameter bit          ROUND_ADD   = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  i_valid,
    input  logic                                  i_ready,
    output logic                                  o_load,
    input  logic [payload_w(WIDTH,SHW,TAG_W)-1:0] i_payload,
    output logic                                  o_valid,
    output logic [payload_w(WIDTH,SHW,TAG_W)-1:0] o_payload
);

    localparam int unsigned PW        = payload_w(WIDTH, SHW, TAG_W);
    localparam int unsigned DW        = 2 * WIDTH;
    localparam int unsigned DATA_LSB  = data_lsb(SHW, TAG_W);
    localparam int unsigned SHAMT_LSB = shamt_lsb(TAG_W);
    localparam int unsigned DIR_BIT   = dir_bit(TAG_W);
    localparam int unsigned ARITH_BIT = arith_bit(TAG_W);
    localparam int unsigned ROUND_BIT = round_bit(TAG_W);

    logic          r_valid;
    logic [PW-1:0] r_payload;
    logic [DW-1:0] w_shift;
    logic [DW-1:0] w_res;
    logic [PW-1:0] w_next;

    assign o_load = !r_valid || i_ready;

    // Apply this stage's shift levels (level k shifts by 2**k when shamt[k] is set).
    always_comb begin
        w_shift = i_payload[DATA_LSB +: DW];
        for (int unsigned k = 0; k < NUM_LEVELS; k++) begin
            if (i_payload[SHAMT_LSB + FIRST_LEVEL + k]) begin
                if (i_payload[DIR_BIT] == DIR_LEFT) begin
                    w_shift = w_shift << (1 << (FIRST_LEVEL + k));
                end else if (i_payload[ARITH_BIT] == FILL_SIGN) begin
                    w_shift = $unsigned($signed(w_shift) >>> (1 << (FIRST_LEVEL + k)));
                end else begin
                    w_shift = w_shift >> (1 << (FIRST_LEVEL + k));
                end
            end
        end
    end

    if (ROUND_ADD) begin : g_round
        assign w_res = w_shift + {{(DW-1){1'b0}}, i_payload[ROUND_BIT]};
    end else begin : g_trunc
        assign w_res = w_shift;
    end

    assign w_next = {w_res, i_payload[DATA_LSB-1:0]};

    // Stage register: flush empties it, otherwise it loads whenever it may advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_payload <= w_next;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule

// File: rtl/log_shift_pipe.sv
// Pipelined sign/zero-fill barrel shifter for the log multipliers' antilog
// stage. Widens the operand to 2*WIDTH and shifts it left or right through
// PIPE_STAGES elastic stages with full backpressure.
// Build option: define LOG_SHIFT_ROUND_EN for round-half-up on right shifts.
module log_shift_pipe
    import log_shift_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SHW         = $clog2(WIDTH),
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHW-1:0]     in_shamt,
    input  logic               in_dir,
    input  logic               in_arith,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned PW       = payload_w(WIDTH, SHW, TAG_W);
    localparam int unsigned DATA_LSB = data_lsb(SHW, TAG_W);
`ifdef LOG_SHIFT_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic [2*WIDTH-1:0] w_ext;
    logic               w_round;
    logic               w_in_fire;
    logic               w_vin  [PIPE_STAGES];
    logic               w_vld  [PIPE_STAGES];
    logic               w_nrdy [PIPE_STAGES];
    logic               w_load [PIPE_STAGES];
    logic [PW-1:0]      w_pl   [PIPE_STAGES+1];

    assign w_ext = (in_arith == FILL_SIGN) ? {{WIDTH{in_data[WIDTH-1]}}, in_data}
                                           : {{WIDTH{1'b0}}, in_data};

    // Round-half-up increment is the last bit shifted out, i.e. ext[shamt-1].
    always_comb begin
        w_round = 1'b0;
`ifdef LOG_SHIFT_ROUND_EN
        w_round = (in_dir == DIR_RIGHT) && (in_shamt != '0) && in_data[in_shamt - SHW'(1)];
`endif
    end

    assign in_ready  = rst_n && !flush && w_load[0];
    assign w_in_fire = in_valid && in_ready;
    assign w_pl[0]   = {w_ext, in_shamt, in_dir, in_arith, w_round, in_tag};

    // Downstream-ready for stage s, flattened from the valid bits so the
    // ready chain has no self-dependency: stage s may advance if out_ready
    // or any later stage has a hole.
    always_comb begin
        for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
            w_nrdy[s] = out_ready;
            for (int unsigned k = s + 1; k < PIPE_STAGES; k++) begin
                if (!w_vld[k]) begin
                    w_nrdy[s] = 1'b1;
                end
            end
        end
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_vin[s] = w_in_fire;
        end else begin : g_rest
            assign w_vin[s] = w_vld[s-1];
        end

        log_shift_stage #(
            .WIDTH       (WIDTH),
            .SHW         (SHW),
            .TAG_W       (TAG_W),
            .FIRST_LEVEL (first_level(s, SHW, PIPE_STAGES)),
            .NUM_LEVELS  (levels_in_stage(s, SHW, PIPE_STAGES)),
            .ROUND_ADD   (ROUND_EN && (s == PIPE_STAGES - 1))
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .i_valid   (w_vin[s]),
            .i_ready   (w_nrdy[s]),
            .o_load    (w_load[s]),
            .i_payload (w_pl[s]),
            .o_valid   (w_vld[s]),
            .o_payload (w_pl[s+1])
        );
    end

    assign out_valid = w_vld[PIPE_STAGES-1];
    assign out_data  = w_pl[PIPE_STAGES][DATA_LSB +: 2*WIDTH];
    assign out_tag   = w_pl[PIPE_STAGES][TAG_W-1:0];

endmodule

// File: tb/tb_log_shift_pipe.sv
// Self-checking bench for log_shift_pipe (WIDTH=16). Directed vector table,
// backpressure / reset / flush sequences on a 2-stage instance, and a
// randomized sweep on 1/2/4-stage instances against an arithmetic model.
module tb_log_shift_pipe;

`ifdef LOG_SHIFT_ROUND_EN
    localparam bit ROUND_ON = 1'b1;
`else
    localparam bit ROUND_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic        in_dir;
    logic        in_arith;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    log_shift_pipe #(.WIDTH(16), .PIPE_STAGES(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_dir(in_dir), .in_arith(in_arith), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    // Randomized sweep instances: index 0/1/2 -> 1/2/4 pipeline stages.
    logic        rv_in_valid  [3];
    logic        rv_in_ready  [3];
    logic [15:0] rv_in_data   [3];
    logic [3:0]  rv_in_shamt  [3];
    logic        rv_in_dir    [3];
    logic        rv_in_arith  [3];
    logic [3:0]  rv_in_tag    [3];
    logic        rv_out_valid [3];
    logic        rv_out_ready [3];
    logic [31:0] rv_out_data  [3];
    logic [3:0]  rv_out_tag   [3];

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int unsigned PS = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        log_shift_pipe #(.WIDTH(16), .PIPE_STAGES(PS), .TAG_W(4)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(1'b0),
            .in_valid(rv_in_valid[g]), .in_ready(rv_in_ready[g]), .in_data(rv_in_data[g]),
            .in_shamt(rv_in_shamt[g]), .in_dir(rv_in_dir[g]), .in_arith(rv_in_arith[g]),
            .in_tag(rv_in_tag[g]), .out_valid(rv_out_valid[g]), .out_ready(rv_out_ready[g]),
            .out_data(rv_out_data[g]), .out_tag(rv_out_tag[g])
        );
    end

    // Reference: shifts as multiplication / floor division on plain integers.
    function automatic logic [31:0] ref_shift(input logic [15:0] d, input int s,
                                              input logic dir, input logic arith);
        longint v, p, q;
        if (arith) v = longint'($signed(d));
        else       v = longint'(d);
        p = longint'(1) << s;
        if (!dir) begin
            q = v * p;
        end else begin
            if (ROUND_ON && s > 0) v = v + p / 2;
            q = v / p;
            if (v < 0 && (v % p) != 0) q = q - 1;
        end
        return q[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [3:0]  shamt;
        logic        dir;
        logic        arith;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    // Backpressure stream item t.
    task automatic drive_bp(input int t);
        logic [15:0] d;
        logic [3:0]  tt;
        d  = 16'h8421 ^ 16'(t * 16'h0F13);
        tt = 4'(t);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 4'(t * 2 + 1);
        in_dir   = tt[0];
        in_arith = tt[1];
        in_tag   = tt;
    endtask

    function automatic logic [31:0] bp_exp(input int t);
        logic [3:0] tt;
        tt = 4'(t);
        return ref_shift(16'h8421 ^ 16'(t * 16'h0F13), t * 2 + 1, tt[0], tt[1]);
    endfunction

    logic [35:0] sb_mem [3][1024];
    int unsigned sb_head [3];
    int unsigned sb_tail [3];
    logic        rv_fire [3];

    task automatic rand_drive(input int g);
        rv_in_valid[g] = 1'($urandom_range(0, 1));
        rv_in_data[g]  = 16'($urandom);
        rv_in_shamt[g] = 4'($urandom_range(0, 15));
        rv_in_dir[g]   = 1'($urandom);
        rv_in_arith[g] = 1'($urandom);
        rv_in_tag[g]   = 4'($urandom);
    endtask

    // One sweep cycle across all three instances; drain=1 stops new input.
    task automatic sweep_cycle(input bit drain);
        logic [35:0] e;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            rv_fire[g] = rv_in_valid[g] && rv_in_ready[g];
            if (rv_out_valid[g] && rv_out_ready[g]) begin
                chk("sweep_queue_nonempty", 32'(sb_tail[g] != sb_head[g]), 32'd1);
                if (sb_tail[g] != sb_head[g]) begin
                    e = sb_mem[g][sb_head[g] % 1024];
                    chk($sformatf("sweep%0d_data", g), rv_out_data[g], e[31:0]);
                    chk($sformatf("sweep%0d_tag", g), 32'(rv_out_tag[g]), 32'(e[35:32]));
                    sb_head[g]++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            if (rv_fire[g]) begin
                sb_mem[g][sb_tail[g] % 1024] = {rv_in_tag[g],
                    ref_shift(rv_in_data[g], int'(rv_in_shamt[g]), rv_in_dir[g], rv_in_arith[g])};
                sb_tail[g]++;
            end
            if (drain) begin
                if (rv_fire[g]) rv_in_valid[g] = 1'b0;
                rv_out_ready[g] = 1'b1;
            end else begin
                if (!rv_in_valid[g] || rv_fire[g]) rand_drive(g);
                rv_out_ready[g] = ($urandom_range(0, 3) != 0);
            end
        end
    endtask

    initial begin
        int lat, acc, rcv, t, stale;
        bit fire;

        vecs[0]  = '{16'h8001, 4'd4,  1'b0, 1'b1, 32'hFFF8_0010};
        vecs[1]  = '{16'h8001, 4'd4,  1'b0, 1'b0, 32'h0008_0010};
        vecs[2]  = '{16'h0001, 4'd15, 1'b0, 1'b0, 32'h0000_8000};
        vecs[3]  = '{16'hFF80, 4'd3,  1'b1, 1'b1, 32'hFFFF_FFF0};
        vecs[4]  = '{16'hFF80, 4'd3,  1'b1, 1'b0, 32'h0000_1FF0};
        vecs[5]  = '{16'h0007, 4'd1,  1'b1, 1'b0, ROUND_ON ? 32'h0000_0004 : 32'h0000_0003};
        vecs[6]  = '{16'h8000, 4'd0,  1'b1, 1'b1, 32'hFFFF_8000};
        vecs[7]  = '{16'h8000, 4'd0,  1'b0, 1'b0, 32'h0000_8000};
        vecs[8]  = '{16'h8000, 4'd15, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[9]  = '{16'h8000, 4'd15, 1'b1, 1'b0, 32'h0000_0001};
        vecs[10] = '{16'hFFFF, 4'd15, 1'b0, 1'b1, 32'hFFFF_8000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        in_dir = 1'b0; in_arith = 1'b0; in_tag = '0; out_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            rv_in_valid[g] = 1'b0; rv_in_data[g] = '0; rv_in_shamt[g] = '0;
            rv_in_dir[g] = 1'b0; rv_in_arith[g] = 1'b0; rv_in_tag[g] = '0;
            rv_out_ready[g] = 1'b0; sb_head[g] = 0; sb_tail[g] = 0; rv_fire[g] = 1'b0;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with latency check
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; in_data = vecs[i].data; in_shamt = vecs[i].shamt;
            in_dir = vecs[i].dir; in_arith = vecs[i].arith; in_tag = 4'(i); out_ready = 1'b1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(i));
            @(posedge clk);
            #1;
        end

        // Backpressure: six tagged inputs with out_ready held low
        out_ready = 1'b0; t = 0; acc = 0;
        drive_bp(0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (fire) acc++;
            if (cyc >= 2) begin
                chk("bp_stall_valid", 32'(out_valid), 32'd1);
                chk("bp_stall_data", out_data, bp_exp(0));
                chk("bp_stall_tag", 32'(out_tag), 32'd0);
            end
            @(posedge clk);
            #1;
            if (fire) begin
                t++;
                if (t < 6) drive_bp(t); else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1; rcv = 0;
        for (int cyc = 0; cyc < 30 && rcv < 6; cyc++) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            if (out_valid) begin
                chk("bp_order_tag", 32'(out_tag), 32'(rcv));
                chk("bp_order_data", out_data, bp_exp(rcv));
                rcv++;
            end
            @(posedge clk);
            #1;
            if (fire) begin
                t++;
                if (t < 6) drive_bp(t); else in_valid = 1'b0;
            end
        end
        chk("bp_received", 32'(rcv), 32'd6);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_dup", 32'(out_valid), 32'd0);

        // Asynchronous reset with two entries in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1234; in_shamt = 4'd2; in_dir = 1'b0; in_arith = 1'b0; in_tag = 4'd10;
        @(posedge clk); #1;
        in_tag = 4'd11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstmid_pre_valid", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_out_data", out_data, 32'd0);
        chk("rstmid_out_tag", 32'(out_tag), 32'd0);
        chk("rstmid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        stale = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rstmid_stale", 32'(stale), 32'd0);

        // Flush with two entries in flight and a new input offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00F0; in_shamt = 4'd1; in_dir = 1'b1; in_arith = 1'b0; in_tag = 4'd12;
        @(posedge clk); #1;
        in_tag = 4'd13;
        @(posedge clk); #1;
        in_tag = 4'd14; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        chk("flush_cycle_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        stale = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("flush_stale", 32'(stale), 32'd0);

        // Random sweep on 1/2/4-stage instances
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) rand_drive(g);
        for (int cyc = 0; cyc < 1500; cyc++) sweep_cycle(1'b0);
        for (int cyc = 0; cyc < 40; cyc++) sweep_cycle(1'b1);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("sweep%0d_drained", g), sb_tail[g] - sb_head[g], 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
